// File: rtl/mc_port_arbiter_if.sv
// Bundle of core-side request/response lanes and the shared MC port seen by mc_port_arbiter.
// slave is the arbiter's view; master is the cores-plus-MC environment's view.
interface mc_port_arbiter_if #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ID_WID          = 2,
  parameter int unsigned MC_RTNCTL_WIDTH = 32,
  parameter int unsigned MAX_OUTST       = 8
);
  localparam int unsigned RW    = MC_RTNCTL_WIDTH - ID_WID;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  // core request lanes, packed per requester
  logic [NUM_REQ-1:0]       req_vld;
  logic [3*NUM_REQ-1:0]     req_cmd;
  logic [4*NUM_REQ-1:0]     req_scmd;
  logic [48*NUM_REQ-1:0]    req_vadr;
  logic [2*NUM_REQ-1:0]     req_size;
  logic [RW*NUM_REQ-1:0]    req_rtnctl;
  logic [64*NUM_REQ-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_stall;

  // shared MC request port
  logic                       mc_rq_vld;
  logic [2:0]                 mc_rq_cmd;
  logic [3:0]                 mc_rq_scmd;
  logic [47:0]                mc_rq_vadr;
  logic [1:0]                 mc_rq_size;
  logic [63:0]                mc_rq_data;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic                       mc_rq_flush;
  logic                       mc_rq_stall;

  // shared MC response port
  logic                       mc_rs_vld;
  logic [2:0]                 mc_rs_cmd;
  logic [3:0]                 mc_rs_scmd;
  logic [63:0]                mc_rs_data;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic                       mc_rs_stall;

  // core response lanes
  logic [NUM_REQ-1:0]       rsp_vld;
  logic [2:0]               rsp_cmd;
  logic [3:0]               rsp_scmd;
  logic [63:0]              rsp_data;
  logic [RW-1:0]            rsp_rtnctl;
  logic [NUM_REQ-1:0]       rsp_stall;

  logic [CNT_W*NUM_REQ-1:0] outst_cnt;

  modport slave (
    input  req_vld, req_cmd, req_scmd, req_vadr, req_size, req_rtnctl, req_data,
    output req_stall,
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_data,
    output mc_rq_rtnctl, mc_rq_flush,
    input  mc_rq_stall,
    input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    output mc_rs_stall,
    output rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
    input  rsp_stall,
    output outst_cnt
  );

  modport master (
    output req_vld, req_cmd, req_scmd, req_vadr, req_size, req_rtnctl, req_data,
    input  req_stall,
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_data,
    input  mc_rq_rtnctl, mc_rq_flush,
    output mc_rq_stall,
    output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    input  mc_rs_stall,
    input  rsp_vld, rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl,
    output rsp_stall,
    input  outst_cnt
  );
endinterface

// File: rtl/mc_port_arbiter.sv
// Round-robin arbiter sharing one MC port among NUM_REQ cores: tags requests with the
// requester ID, limits in-flight requests per core and steers responses back by ID.
module mc_port_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ID_WID          = 2,
  parameter int unsigned MC_RTNCTL_WIDTH = 32,
  parameter int unsigned MAX_OUTST       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_port_arbiter_if.slave bus
);
  localparam int unsigned RW    = MC_RTNCTL_WIDTH - ID_WID;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned PTR_W = ID_WID + 1;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [3:0]    scmd;
    logic [47:0]   vadr;
    logic [1:0]    size;
    logic [RW-1:0] rtnctl;
    logic [63:0]   data;
  } rq_pl_t;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [3:0]    scmd;
    logic [RW-1:0] rtnctl;
    logic [63:0]   data;
  } rs_pl_t;

  rq_pl_t             req_pl [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [PTR_W-1:0]   cand;
  logic [ID_WID-1:0]  cand_id;
  logic               win_vld;
  logic [ID_WID-1:0]  win_id;
  rq_pl_t             win_pl;
  logic               advance;
  logic               accept;
  logic [ID_WID-1:0]  rr_ptr;
  logic [ID_WID-1:0]  rr_ptr_nxt;

  logic               mc_rq_vld_q;
  logic [ID_WID-1:0]  mc_rq_id_q;
  rq_pl_t             mc_rq_pl_q;

  logic [ID_WID-1:0]  rs_id;
  logic               rs_known;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic [ID_WID-1:0]  h_id;
  rs_pl_t             h_pl;
  logic               h_vld;
  logic               h_stall;
  logic               drain;
  logic               load;

  logic [CNT_W-1:0]   outst [NUM_REQ];
  logic [NUM_REQ-1:0] inc;
  logic [NUM_REQ-1:0] dec;

  // unpack per-requester request lanes
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_pl[i].cmd    = bus.req_cmd[i*3 +: 3];
      req_pl[i].scmd   = bus.req_scmd[i*4 +: 4];
      req_pl[i].vadr   = bus.req_vadr[i*48 +: 48];
      req_pl[i].size   = bus.req_size[i*2 +: 2];
      req_pl[i].rtnctl = bus.req_rtnctl[i*RW +: RW];
      req_pl[i].data   = bus.req_data[i*64 +: 64];
      elig[i]          = bus.req_vld[i] & (outst[i] < CNT_W'(MAX_OUTST));
    end
  end

  // first eligible requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    cand_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + PTR_W'(k);
      if (cand >= PTR_W'(NUM_REQ)) begin
        cand = cand - PTR_W'(NUM_REQ);
      end
      cand_id = cand[ID_WID-1:0];
      if (!win_vld && elig[cand_id]) begin
        win_vld = 1'b1;
        win_id  = cand_id;
      end
    end
  end

  always_comb begin
    win_pl = req_pl[0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (win_id == ID_WID'(i)) begin
        win_pl = req_pl[i];
      end
    end
  end

  assign advance    = ~bus.mc_rq_stall;
  assign accept     = rst_n & advance & win_vld;
  assign rr_ptr_nxt = (32'(win_id) == NUM_REQ - 1) ? '0 : win_id + ID_WID'(1);

  // request output stage: holds under MC back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      mc_rq_vld_q <= 1'b0;
      mc_rq_id_q  <= '0;
      mc_rq_pl_q  <= '0;
    end else if (advance) begin
      mc_rq_vld_q <= win_vld;
      if (win_vld) begin
        mc_rq_id_q <= win_id;
        mc_rq_pl_q <= win_pl;
        rr_ptr     <= rr_ptr_nxt;
      end
    end
  end

  // response holding register; ID >= NUM_REQ is consumed and dropped
  assign rs_id    = bus.mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: ID_WID];
  assign rs_known = (32'(rs_id) < NUM_REQ);
  assign h_vld    = |rsp_vld_q;
  assign h_stall  = h_vld & bus.rsp_stall[h_id];
  assign drain    = h_vld & ~h_stall;
  assign load     = bus.mc_rs_vld & ~h_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= '0;
      h_id      <= '0;
      h_pl      <= '0;
    end else if (load) begin
      rsp_vld_q <= rs_known ? (NUM_REQ'(1) << rs_id) : '0;
      if (rs_known) begin
        h_id        <= rs_id;
        h_pl.cmd    <= bus.mc_rs_cmd;
        h_pl.scmd   <= bus.mc_rs_scmd;
        h_pl.rtnctl <= bus.mc_rs_rtnctl[RW-1:0];
        h_pl.data   <= bus.mc_rs_data;
      end
    end else if (drain) begin
      rsp_vld_q <= '0;
    end
  end

  // per-requester in-flight accounting
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i] = accept & (win_id == ID_WID'(i));
      dec[i] = drain & (h_id == ID_WID'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        outst[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i]) begin
          outst[i] <= outst[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i] && (outst[i] != '0)) begin
          outst[i] <= outst[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    bus.outst_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.outst_cnt[i*CNT_W +: CNT_W] = outst[i];
    end
  end

  assign bus.req_stall    = ~inc;
  assign bus.mc_rq_vld    = mc_rq_vld_q;
  assign bus.mc_rq_cmd    = mc_rq_pl_q.cmd;
  assign bus.mc_rq_scmd   = mc_rq_pl_q.scmd;
  assign bus.mc_rq_vadr   = mc_rq_pl_q.vadr;
  assign bus.mc_rq_size   = mc_rq_pl_q.size;
  assign bus.mc_rq_data   = mc_rq_pl_q.data;
  assign bus.mc_rq_rtnctl = {mc_rq_id_q, mc_rq_pl_q.rtnctl};
  assign bus.mc_rq_flush  = 1'b0;
  assign bus.mc_rs_stall  = h_stall;
  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_cmd      = h_pl.cmd;
  assign bus.rsp_scmd     = h_pl.scmd;
  assign bus.rsp_data     = h_pl.data;
  assign bus.rsp_rtnctl   = h_pl.rtnctl;
endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter: arbitration order, back-pressure, outstanding limit
// and asynchronous reset, each scenario checked against hand-computed values.
module tb_mc_port_arbiter;
  localparam int unsigned NUM_REQ         = 4;
  localparam int unsigned ID_WID          = 2;
  localparam int unsigned MC_RTNCTL_WIDTH = 32;
  localparam int unsigned MAX_OUTST       = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_port_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ID_WID(ID_WID),
    .MC_RTNCTL_WIDTH(MC_RTNCTL_WIDTH), .MAX_OUTST(MAX_OUTST)
  ) bus ();

  mc_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_WID(ID_WID),
    .MC_RTNCTL_WIDTH(MC_RTNCTL_WIDTH), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_vld      = '0;
    bus.req_cmd      = '0;
    bus.req_scmd     = '0;
    bus.req_vadr     = '0;
    bus.req_size     = '0;
    bus.req_rtnctl   = '0;
    bus.req_data     = '0;
    bus.mc_rq_stall  = 1'b0;
    bus.mc_rs_vld    = 1'b0;
    bus.mc_rs_cmd    = '0;
    bus.mc_rs_scmd   = '0;
    bus.mc_rs_data   = '0;
    bus.mc_rs_rtnctl = '0;
    bus.rsp_stall    = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req_vld = 4'hF;
    #12;
    checks++; if (bus.req_stall !== 4'hF) begin errors++; $display("FAIL reset_req_stall: got %h exp f", bus.req_stall); end
    checks++; if (bus.mc_rq_vld !== 1'b0) begin errors++; $display("FAIL reset_mc_rq_vld: got %h exp 0", bus.mc_rq_vld); end
    checks++; if (bus.mc_rq_rtnctl !== 32'h0) begin errors++; $display("FAIL reset_mc_rq_rtnctl: got %h exp 0", bus.mc_rq_rtnctl); end
    checks++; if (bus.mc_rq_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %h exp 0", bus.mc_rq_flush); end
    checks++; if (bus.rsp_vld !== 4'h0) begin errors++; $display("FAIL reset_rsp_vld: got %h exp 0", bus.rsp_vld); end
    checks++; if (bus.mc_rs_stall !== 1'b0) begin errors++; $display("FAIL reset_mc_rs_stall: got %h exp 0", bus.mc_rs_stall); end
    checks++; if (bus.outst_cnt !== 16'h0) begin errors++; $display("FAIL reset_outst: got %h exp 0", bus.outst_cnt); end
    bus.req_vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.req_vld           = 4'b0100;
    bus.req_vadr[96 +: 48] = 48'h1000;
    bus.req_rtnctl[60 +: 30] = 30'h5;
    #1;
    checks++; if (bus.req_stall !== 4'b1011) begin errors++; $display("FAIL single_req_stall: got %b exp 1011", bus.req_stall); end
    step();
    bus.req_vld = '0;
    checks++; if (bus.mc_rq_vld !== 1'b1) begin errors++; $display("FAIL single_mc_rq_vld: got %h exp 1", bus.mc_rq_vld); end
    checks++; if (bus.mc_rq_vadr !== 48'h1000) begin errors++; $display("FAIL single_vadr: got %h exp 1000", bus.mc_rq_vadr); end
    checks++; if (bus.mc_rq_rtnctl !== 32'h8000_0005) begin errors++; $display("FAIL single_rtnctl: got %h exp 80000005", bus.mc_rq_rtnctl); end
    checks++; if (bus.outst_cnt[11:8] !== 4'd1) begin errors++; $display("FAIL single_outst_inc: got %0d exp 1", bus.outst_cnt[11:8]); end
    step();
    checks++; if (bus.mc_rq_vld !== 1'b0) begin errors++; $display("FAIL single_idle: got %h exp 0", bus.mc_rq_vld); end
    bus.mc_rs_vld    = 1'b1;
    bus.mc_rs_rtnctl = 32'h8000_0005;
    bus.mc_rs_data   = 64'hDEAD_BEEF_0000_0002;
    #1;
    checks++; if (bus.mc_rs_stall !== 1'b0) begin errors++; $display("FAIL single_mc_rs_stall: got %h exp 0", bus.mc_rs_stall); end
    step();
    bus.mc_rs_vld = 1'b0;
    checks++; if (bus.rsp_vld !== 4'b0100) begin errors++; $display("FAIL single_rsp_vld: got %b exp 0100", bus.rsp_vld); end
    checks++; if (bus.rsp_rtnctl !== 30'h5) begin errors++; $display("FAIL single_rsp_rtnctl: got %h exp 5", bus.rsp_rtnctl); end
    checks++; if (bus.rsp_data !== 64'hDEAD_BEEF_0000_0002) begin errors++; $display("FAIL single_rsp_data: got %h exp deadbeef00000002", bus.rsp_data); end
    step();
    checks++; if (bus.rsp_vld !== 4'b0000) begin errors++; $display("FAIL single_rsp_drain: got %b exp 0000", bus.rsp_vld); end
    checks++; if (bus.outst_cnt[11:8] !== 4'd0) begin errors++; $display("FAIL single_outst_dec: got %0d exp 0", bus.outst_cnt[11:8]); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_stall;
    logic [47:0] exp_vadr;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_vadr[i*48 +: 48] = 48'h100 * 48'(i + 1);
    end
    bus.req_vld = 4'hF;
    for (int c = 0; c < 8; c++) begin
      exp_stall = ~(4'b0001 << (c % 4));
      exp_vadr  = 48'h100 * 48'((c % 4) + 1);
      #1;
      checks++; if (bus.req_stall !== exp_stall) begin errors++; $display("FAIL rr_req_stall[%0d]: got %b exp %b", c, bus.req_stall, exp_stall); end
      step();
      checks++; if (bus.mc_rq_vld !== 1'b1 || bus.mc_rq_rtnctl[31:30] !== 2'(c % 4) || bus.mc_rq_vadr !== exp_vadr)
        begin errors++; $display("FAIL rr_grant[%0d]: got vld=%h id=%0d vadr=%h exp vld=1 id=%0d vadr=%h", c, bus.mc_rq_vld, bus.mc_rq_rtnctl[31:30], bus.mc_rq_vadr, c % 4, exp_vadr); end
    end
    checks++; if (bus.outst_cnt !== 16'h2222) begin errors++; $display("FAIL rr_outst: got %h exp 2222", bus.outst_cnt); end
  endtask

  task automatic test_mc_rq_stall();
    #1;
    checks++; if (bus.req_stall !== 4'b1110) begin errors++; $display("FAIL stall_pre_grant: got %b exp 1110", bus.req_stall); end
    step();
    bus.mc_rq_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.req_stall !== 4'hF) begin errors++; $display("FAIL stall_req_stall[%0d]: got %b exp 1111", c, bus.req_stall); end
      step();
      checks++; if (bus.mc_rq_vld !== 1'b1 || bus.mc_rq_rtnctl[31:30] !== 2'd0 || bus.mc_rq_vadr !== 48'h100)
        begin errors++; $display("FAIL stall_hold[%0d]: got vld=%h id=%0d vadr=%h exp vld=1 id=0 vadr=100", c, bus.mc_rq_vld, bus.mc_rq_rtnctl[31:30], bus.mc_rq_vadr); end
    end
    bus.mc_rq_stall = 1'b0;
    #1;
    checks++; if (bus.req_stall !== 4'b1101) begin errors++; $display("FAIL stall_resume_stall: got %b exp 1101", bus.req_stall); end
    step();
    bus.req_vld = '0;
    checks++; if (bus.mc_rq_rtnctl[31:30] !== 2'd1 || bus.mc_rq_vadr !== 48'h200) begin errors++; $display("FAIL stall_resume_grant: got id=%0d vadr=%h exp id=1 vadr=200", bus.mc_rq_rtnctl[31:30], bus.mc_rq_vadr); end
    step();
    checks++; if (bus.mc_rq_vld !== 1'b0) begin errors++; $display("FAIL stall_idle: got %h exp 0", bus.mc_rq_vld); end
    checks++; if (bus.outst_cnt !== 16'h2233) begin errors++; $display("FAIL stall_outst: got %h exp 2233", bus.outst_cnt); end
  endtask

  task automatic test_rsp_backpressure();
    bus.rsp_stall    = 4'b0010;
    bus.mc_rs_vld    = 1'b1;
    bus.mc_rs_rtnctl = 32'h4000_0011;
    bus.mc_rs_data   = 64'h1111;
    #1;
    checks++; if (bus.mc_rs_stall !== 1'b0) begin errors++; $display("FAIL bp_first_accept: got %h exp 0", bus.mc_rs_stall); end
    step();
    checks++; if (bus.rsp_vld !== 4'b0010 || bus.rsp_data !== 64'h1111) begin errors++; $display("FAIL bp_first_load: got vld=%b data=%h exp vld=0010 data=1111", bus.rsp_vld, bus.rsp_data); end
    bus.mc_rs_rtnctl = 32'h4000_0022;
    bus.mc_rs_data   = 64'h2222;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.mc_rs_stall !== 1'b1) begin errors++; $display("FAIL bp_mc_rs_stall[%0d]: got %h exp 1", c, bus.mc_rs_stall); end
      step();
      checks++; if (bus.rsp_vld !== 4'b0010 || bus.rsp_data !== 64'h1111 || bus.rsp_rtnctl !== 30'h11)
        begin errors++; $display("FAIL bp_hold[%0d]: got vld=%b data=%h tag=%h exp vld=0010 data=1111 tag=11", c, bus.rsp_vld, bus.rsp_data, bus.rsp_rtnctl); end
    end
    bus.rsp_stall = '0;
    #1;
    checks++; if (bus.mc_rs_stall !== 1'b0) begin errors++; $display("FAIL bp_release: got %h exp 0", bus.mc_rs_stall); end
    step();
    bus.mc_rs_vld = 1'b0;
    checks++; if (bus.rsp_vld !== 4'b0010 || bus.rsp_data !== 64'h2222 || bus.rsp_rtnctl !== 30'h22)
      begin errors++; $display("FAIL bp_second: got vld=%b data=%h tag=%h exp vld=0010 data=2222 tag=22", bus.rsp_vld, bus.rsp_data, bus.rsp_rtnctl); end
    checks++; if (bus.outst_cnt[7:4] !== 4'd2) begin errors++; $display("FAIL bp_outst_mid: got %0d exp 2", bus.outst_cnt[7:4]); end
    step();
    checks++; if (bus.rsp_vld !== 4'b0000) begin errors++; $display("FAIL bp_drained: got %b exp 0000", bus.rsp_vld); end
    checks++; if (bus.outst_cnt[7:4] !== 4'd1) begin errors++; $display("FAIL bp_outst_end: got %0d exp 1", bus.outst_cnt[7:4]); end
  endtask

  task automatic test_max_outst();
    apply_reset();
    bus.req_vld = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (bus.req_stall !== 4'b1110) begin errors++; $display("FAIL max_fill[%0d]: got %b exp 1110", c, bus.req_stall); end
      step();
    end
    checks++; if (bus.outst_cnt[3:0] !== 4'd8) begin errors++; $display("FAIL max_outst_full: got %0d exp 8", bus.outst_cnt[3:0]); end
    #1;
    checks++; if (bus.req_stall !== 4'hF) begin errors++; $display("FAIL max_ninth_stalled: got %b exp 1111", bus.req_stall); end
    step();
    checks++; if (bus.mc_rq_vld !== 1'b0) begin errors++; $display("FAIL max_no_issue: got %h exp 0", bus.mc_rq_vld); end
    bus.req_vld = 4'b0011;
    #1;
    checks++; if (bus.req_stall !== 4'b1101) begin errors++; $display("FAIL max_other_granted: got %b exp 1101", bus.req_stall); end
    step();
    checks++; if (bus.mc_rq_vld !== 1'b1 || bus.mc_rq_rtnctl[31:30] !== 2'd1) begin errors++; $display("FAIL max_other_issue: got vld=%h id=%0d exp vld=1 id=1", bus.mc_rq_vld, bus.mc_rq_rtnctl[31:30]); end
    bus.req_vld      = 4'b0001;
    bus.mc_rs_vld    = 1'b1;
    bus.mc_rs_rtnctl = 32'h0000_0007;
    step();
    bus.mc_rs_vld = 1'b0;
    checks++; if (bus.rsp_vld !== 4'b0001 || bus.outst_cnt[3:0] !== 4'd8) begin errors++; $display("FAIL max_rsp_held: got vld=%b cnt=%0d exp vld=0001 cnt=8", bus.rsp_vld, bus.outst_cnt[3:0]); end
    #1;
    checks++; if (bus.req_stall !== 4'hF) begin errors++; $display("FAIL max_still_full: got %b exp 1111", bus.req_stall); end
    step();
    checks++; if (bus.outst_cnt[3:0] !== 4'd7) begin errors++; $display("FAIL max_after_rsp: got %0d exp 7", bus.outst_cnt[3:0]); end
    #1;
    checks++; if (bus.req_stall !== 4'b1110) begin errors++; $display("FAIL max_reenabled: got %b exp 1110", bus.req_stall); end
    step();
    bus.req_vld = '0;
    checks++; if (bus.mc_rq_vld !== 1'b1 || bus.mc_rq_rtnctl[31:30] !== 2'd0 || bus.outst_cnt[3:0] !== 4'd8)
      begin errors++; $display("FAIL max_reissue: got vld=%h id=%0d cnt=%0d exp vld=1 id=0 cnt=8", bus.mc_rq_vld, bus.mc_rq_rtnctl[31:30], bus.outst_cnt[3:0]); end
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_vadr[i*48 +: 48] = 48'h4000 + 48'(i);
    end
    bus.req_vld = 4'b0111;
    step();
    step();
    step();
    bus.mc_rq_stall  = 1'b1;
    bus.rsp_stall    = 4'b0001;
    bus.mc_rs_vld    = 1'b1;
    bus.mc_rs_rtnctl = 32'h0000_0003;
    step();
    bus.mc_rs_vld = 1'b0;
    checks++; if (bus.mc_rq_vld !== 1'b1 || bus.mc_rq_vadr !== 48'h4002 || bus.outst_cnt !== 16'h0111 || bus.rsp_vld !== 4'b0001)
      begin errors++; $display("FAIL inflight_setup: got vld=%h vadr=%h cnt=%h rsp=%b exp vld=1 vadr=4002 cnt=0111 rsp=0001", bus.mc_rq_vld, bus.mc_rq_vadr, bus.outst_cnt, bus.rsp_vld); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mc_rq_vld !== 1'b0 || bus.mc_rq_vadr !== 48'h0 || bus.mc_rq_rtnctl !== 32'h0)
      begin errors++; $display("FAIL inflight_mc_rq: got vld=%h vadr=%h rtnctl=%h exp all 0", bus.mc_rq_vld, bus.mc_rq_vadr, bus.mc_rq_rtnctl); end
    checks++; if (bus.rsp_vld !== 4'b0000 || bus.rsp_rtnctl !== 30'h0) begin errors++; $display("FAIL inflight_rsp: got vld=%b tag=%h exp 0", bus.rsp_vld, bus.rsp_rtnctl); end
    checks++; if (bus.outst_cnt !== 16'h0) begin errors++; $display("FAIL inflight_outst: got %h exp 0", bus.outst_cnt); end
    checks++; if (bus.req_stall !== 4'hF || bus.mc_rs_stall !== 1'b0) begin errors++; $display("FAIL inflight_stalls: got req=%b rs=%h exp req=1111 rs=0", bus.req_stall, bus.mc_rs_stall); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (bus.mc_rq_vld !== 1'b0 || bus.rsp_vld !== 4'b0000) begin errors++; $display("FAIL inflight_post: got mc=%h rsp=%b exp 0", bus.mc_rq_vld, bus.rsp_vld); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish exp finish before 1ms");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mc_rq_stall();
    test_rsp_backpressure();
    test_max_outst();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
